mat_stream_pack: RTL and testbench

//  Element-to-matrix packer. It is the producer end of the matrix stb/ack interface used by the linalg blocks (mat_sum, etc.).
//  - Accepts 32-bit elements one at a time on a stb/ack handshake.
//  - Assembles M*N of them into a row-major matrix.
//  - Presents the matrix on output_mat/output_mat_stb until the downstream consumer acks.

---
 rtl/mat_stream_pack.sv | 99 +++++++++
 tb/tb_mat_stream_pack.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_stream_pack.sv
// mat_stream_pack: collects M*N 32-bit elements from a stb/ack stream and
// presents them as one row-major matrix on a stb/ack output port.
// Element k (arrival order) lands at bits [32k+31:32k], so row 0, col 0
// sits at the LSBs.
module mat_stream_pack #(
    parameter int M = 1,
    parameter int N = 1,
    localparam int ELEMS = M * N,
    localparam int CW = (ELEMS > 1) ? $clog2(ELEMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           input_elem,
    input  logic                  input_elem_stb,
    output logic                  input_elem_ack,
    output logic [ELEMS*32-1:0]   output_mat,
    output logic                  output_mat_stb,
    input  logic                  output_mat_ack,
    output logic [CW-1:0]         elem_count
);

    typedef enum logic {
        COLLECT,
        PUT_MAT
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(ELEMS - 1);

    state_t                   state, state_d;
    logic [ELEMS-1:0][31:0]   mat_buf, mat_buf_d;
    logic [CW-1:0]            count_d;
    logic                     ack_d;
    logic                     stb_d;
    logic [ELEMS*32-1:0]      mat_d;

    // State and all registered outputs; reset discards any partial matrix.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= COLLECT;
            elem_count     <= '0;
            // NOTE: the element buffer is cleared on reset so a matrix can
            // never expose words left over from an aborted collection.
            mat_buf        <= '0;
            input_elem_ack <= 1'b0;
            output_mat     <= '0;
            output_mat_stb <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the values computed before this edge, independent of order.
            state          <= state_d;
            elem_count     <= count_d;
            mat_buf        <= mat_buf_d;
            input_elem_ack <= ack_d;
            output_mat     <= mat_d;
            output_mat_stb <= stb_d;
        end
    end

    // Next-state logic: accept elements in COLLECT, hold the matrix in PUT_MAT.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_d   = state;
        count_d   = elem_count;
        mat_buf_d = mat_buf;
        ack_d     = input_elem_ack;
        mat_d     = output_mat;
        stb_d     = output_mat_stb;

        case (state)
            COLLECT: begin
                if (input_elem_stb && input_elem_ack) begin
                    mat_buf_d[elem_count] = input_elem;
                    ack_d = 1'b0;
                    if (elem_count == LAST) begin
                        count_d = '0;
                        state_d = PUT_MAT;
                    end else begin
                        count_d = elem_count + CW'(1);
                    end
                end else begin
                    ack_d = 1'b1;
                end
            end
            PUT_MAT: begin
                ack_d = 1'b0;
                if (output_mat_stb && output_mat_ack) begin
                    stb_d   = 1'b0;
                    state_d = COLLECT;
                end else begin
                    mat_d = mat_buf;
                    stb_d = 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

endmodule

// File: tb/tb_mat_stream_pack.sv
// Self-checking bench for mat_stream_pack: a 2x2 instance for the main
// scenarios and a 1x1 instance for the degenerate case. Expected matrices
// are queued when their last element is driven and popped when the DUT
// raises output_mat_stb.
module tb_mat_stream_pack;

    logic clk;
    logic rst;

    logic [31:0]  e22;
    logic         e22_stb;
    logic         a22;
    logic [127:0] m22;
    logic         ms22;
    logic         ma22;
    logic [1:0]   c22;

    logic [31:0]  e11;
    logic         e11_stb;
    logic         a11;
    logic [31:0]  m11;
    logic         ms11;
    logic         ma11;
    logic [0:0]   c11;

    int checks = 0;
    int failures = 0;

    logic [127:0] sb22[$];
    logic [31:0]  sb11[$];
    logic [127:0] exp22;
    logic [31:0]  exp11;

    mat_stream_pack #(.M(2), .N(2)) u_dut22 (
        .clk            (clk),
        .rst            (rst),
        .input_elem     (e22),
        .input_elem_stb (e22_stb),
        .input_elem_ack (a22),
        .output_mat     (m22),
        .output_mat_stb (ms22),
        .output_mat_ack (ma22),
        .elem_count     (c22)
    );

    mat_stream_pack #(.M(1), .N(1)) u_dut11 (
        .clk            (clk),
        .rst            (rst),
        .input_elem     (e11),
        .input_elem_stb (e11_stb),
        .input_elem_ack (a11),
        .output_mat     (m11),
        .output_mat_stb (ms11),
        .output_mat_ack (ma11),
        .elem_count     (c11)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one element to the 2x2 packer and return after the transfer edge.
    task automatic send22(input string tag, input logic [31:0] d);
        int n = 0;
        e22_stb = 1'b1;
        e22 = d;
        while (!a22 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_ack_ready"}, 128'(a22), 128'(1));
        step();
        e22_stb = 1'b0;
    endtask

    task automatic send11(input string tag, input logic [31:0] d);
        int n = 0;
        e11_stb = 1'b1;
        e11 = d;
        while (!a11 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_ack_ready"}, 128'(a11), 128'(1));
        step();
        e11_stb = 1'b0;
    endtask

    // Wait (bounded) for the 2x2 matrix strobe and score the matrix.
    task automatic wait_mat22(input string tag);
        int n = 0;
        while (!ms22 && n < 50) begin
            step();
            n++;
        end
        check({tag, "_stb"}, 128'(ms22), 128'(1));
        exp22 = (sb22.size() > 0) ? sb22.pop_front() : 128'hx;
        check({tag, "_mat"}, m22, exp22);
        check({tag, "_count"}, 128'(c22), 128'(0));
    endtask

    initial begin
        logic [31:0] w1[4];
        logic [31:0] w3[4];
        logic [31:0] w4[4];
        logic [31:0] w6a[4];
        logic [31:0] w6b[4];
        w1  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        w3  = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        w4  = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};
        w6a = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004};
        w6b = '{32'h10000000, 32'h20000000, 32'h30000000, 32'h40000000};

        rst = 1'b1;
        e22 = '0; e22_stb = 1'b0; ma22 = 1'b0;
        e11 = '0; e11_stb = 1'b0; ma11 = 1'b0;

        // Reset state
        step();
        step();
        check("rst_ack", 128'(a22), 128'(0));
        check("rst_stb", 128'(ms22), 128'(0));
        check("rst_mat", m22, 128'(0));
        check("rst_count", 128'(c22), 128'(0));
        rst = 1'b0;
        step();
        check("rst_ack_after", 128'(a22), 128'(1));

        // 1: stb held high, ack alternates 1,0,...; matrix in row-major order
        e22_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t1_ack_hi", 128'(a22), 128'(1));
            e22 = w1[i];
            step();
            check("t1_ack_lo", 128'(a22), 128'(0));
            check("t1_count", 128'(c22), 128'((i + 1) % 4));
            if (i < 3) step();
        end
        check("t1_stb_not_yet", 128'(ms22), 128'(0));
        sb22.push_back({w1[3], w1[2], w1[1], w1[0]});
        e22_stb = 1'b0;
        step();
        check("t1_stb_rise", 128'(ms22), 128'(1));
        exp22 = sb22.pop_front();
        check("t1_mat", m22, exp22);

        // 2: backpressure for 10 cycles with an element offered meanwhile
        e22_stb = 1'b1;
        e22 = 32'hBADBAD00;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t2_stb", 128'(ms22), 128'(1));
            check("t2_mat", m22, exp22);
            check("t2_ack", 128'(a22), 128'(0));
            check("t2_count", 128'(c22), 128'(0));
        end
        e22_stb = 1'b0;
        ma22 = 1'b1;
        step();
        ma22 = 1'b0;
        check("t2_stb_drop", 128'(ms22), 128'(0));
        check("t2_ack_still_lo", 128'(a22), 128'(0));
        step();
        check("t2_ack_back", 128'(a22), 128'(1));
        check("t2_not_consumed", 128'(c22), 128'(0));

        // 3: gapped input, consumer ack held high permanently
        ma22 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e22_stb = 1'b1;
            e22 = w3[k];
            step();
            e22_stb = 1'b0;
            e22 = 32'hFFFFFFFF;
            check("t3_count", 128'(c22), 128'((k + 1) % 4));
            if (k < 3) begin
                repeat (4) step();
                check("t3_count_idle", 128'(c22), 128'(k + 1));
            end
        end
        sb22.push_back({w3[3], w3[2], w3[1], w3[0]});
        wait_mat22("t3");
        step();
        check("t3_taken", 128'(ms22), 128'(0));
        ma22 = 1'b0;

        // 4: reset after two elements, then a clean matrix
        step();
        send22("t4_pre0", 32'hDEAD0000);
        send22("t4_pre1", 32'hDEAD0001);
        rst = 1'b1;
        step();
        check("t4_rst_ack", 128'(a22), 128'(0));
        check("t4_rst_stb", 128'(ms22), 128'(0));
        check("t4_rst_mat", m22, 128'(0));
        check("t4_rst_count", 128'(c22), 128'(0));
        rst = 1'b0;
        step();
        for (int k = 0; k < 4; k++) send22("t4", w4[k]);
        sb22.push_back({w4[3], w4[2], w4[1], w4[0]});
        wait_mat22("t4");
        ma22 = 1'b1;
        step();
        ma22 = 1'b0;

        // 6: back-to-back matrices, first acked after 3 cycles
        for (int k = 0; k < 4; k++) send22("t6a", w6a[k]);
        sb22.push_back({w6a[3], w6a[2], w6a[1], w6a[0]});
        wait_mat22("t6a");
        e22_stb = 1'b1;
        e22 = w6b[0];
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_hold_ack", 128'(a22), 128'(0));
            check("t6_hold_count", 128'(c22), 128'(0));
            check("t6_hold_stb", 128'(ms22), 128'(1));
        end
        ma22 = 1'b1;
        step();
        ma22 = 1'b0;
        check("t6_first_taken", 128'(ms22), 128'(0));
        check("t6_second_not_started", 128'(c22), 128'(0));
        for (int k = 0; k < 4; k++) send22("t6b", w6b[k]);
        sb22.push_back({w6b[3], w6b[2], w6b[1], w6b[0]});
        wait_mat22("t6b");
        ma22 = 1'b1;
        step();
        ma22 = 1'b0;

        // 5: 1x1 packer, every element is a matrix
        check("t5_ready", 128'(a11), 128'(1));
        for (int k = 0; k < 2; k++) begin
            exp11 = (k == 0) ? 32'hDEADBEEF : 32'h12345678;
            send11("t5", exp11);
            sb11.push_back(exp11);
            check("t5_count_xfer", 128'(c11), 128'(0));
            check("t5_stb_not_yet", 128'(ms11), 128'(0));
            step();
            check("t5_stb", 128'(ms11), 128'(1));
            exp11 = (sb11.size() > 0) ? sb11.pop_front() : 32'hx;
            check("t5_mat", 128'(m11), 128'(exp11));
            check("t5_count_stb", 128'(c11), 128'(0));
            ma11 = 1'b1;
            step();
            ma11 = 1'b0;
            check("t5_taken", 128'(ms11), 128'(0));
            step();
            check("t5_ready_again", 128'(a11), 128'(1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
